// File: rtl/memory_access.sv
// MEM stage: one outstanding data-memory access over req/ack, store lane encoding, load extension.
// Define MEM_TIMEOUT_EN to add an ack watchdog that drops the bundle with access_fault.
package memory_access_pkg;
    localparam int REGISTER_DESCRIPTOR_WIDTH = 5;
    typedef enum logic [3:0] {
        KIND_ALU, KIND_LB, KIND_LH, KIND_LW, KIND_LBU, KIND_LHU, KIND_SB, KIND_SH, KIND_SW
    } instr_kind_t;
endpackage

module memory_access
    import memory_access_pkg::*;
#(
    parameter int OPERAND_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 valid_input,
    input  logic                                 stall_input,
    input  instr_kind_t                          instr_kind_input,
    input  logic [OPERAND_WIDTH-1:0]             new_register_value,
    input  logic [OPERAND_WIDTH-1:0]             read_memory_address,
    input  logic [OPERAND_WIDTH-1:0]             write_memory_address,
    input  logic [OPERAND_WIDTH-1:0]             new_memory_value,
    input  logic [REGISTER_DESCRIPTOR_WIDTH-1:0] rd_addr_input,
    input  logic                                 write_register,
    input  logic                                 read_memory,
    input  logic                                 write_memory,
    output logic                                 stall_output,
    output logic                                 mem_req,
    output logic                                 mem_we,
    output logic [OPERAND_WIDTH-1:0]             mem_addr,
    output logic [3:0]                           mem_wstrb,
    output logic [OPERAND_WIDTH-1:0]             mem_wdata,
    input  logic                                 mem_ack,
    input  logic [OPERAND_WIDTH-1:0]             mem_rdata,
    output logic                                 valid_output,
    output logic [REGISTER_DESCRIPTOR_WIDTH-1:0] rd_addr_output,
    output logic                                 write_register_output,
    output logic [OPERAND_WIDTH-1:0]             register_value_output,
    output logic                                 misaligned,
    output logic                                 access_fault
);
    if (OPERAND_WIDTH != 32 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("memory_access: OPERAND_WIDTH must be 32 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic {S_IDLE, S_WAIT_ACK} state_t;

    function automatic logic [2:0] kind_bytes(input instr_kind_t k);
        case (k)
            KIND_LB, KIND_LBU, KIND_SB: return 3'd1;
            KIND_LH, KIND_LHU, KIND_SH: return 3'd2;
            default:                    return 3'd4;
        endcase
    endfunction

    state_t                               state_q, state_d;
    logic                                 mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [OPERAND_WIDTH-1:0]             mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [3:0]                           mem_wstrb_q, mem_wstrb_d;
    instr_kind_t                          kind_q, kind_d;
    logic [1:0]                           off_q, off_d;
    logic [REGISTER_DESCRIPTOR_WIDTH-1:0] rd_q, rd_d, out_rd_q, out_rd_d;
    logic                                 valid_q, valid_d, out_wr_q, out_wr_d;
    logic [OPERAND_WIDTH-1:0]             out_val_q, out_val_d;
    logic                                 mis_q, mis_d, fault_q, fault_d;

    logic                     is_mem, out_free, acc_mis, timeout;
    logic [OPERAND_WIDTH-1:0] acc_addr, st_data, lane_word, load_val;
    logic [1:0]               acc_off;
    logic [2:0]               acc_bytes;
    logic [3:0]               st_strb;

    assign is_mem    = read_memory | write_memory;
    assign acc_addr  = write_memory ? write_memory_address : read_memory_address;
    assign acc_off   = acc_addr[1:0];
    assign acc_bytes = kind_bytes(instr_kind_input);
    assign acc_mis   = (acc_bytes == 3'd2 && acc_off[0]) || (acc_bytes == 3'd4 && acc_off != 2'd0);
    assign out_free  = !valid_q || !stall_input;

`ifdef MEM_TIMEOUT_EN
    logic [31:0] cnt_q, cnt_d;
    assign timeout = (state_q == S_WAIT_ACK) && !mem_ack && (cnt_q == 32'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        st_strb = 4'b1111;
        st_data = new_memory_value;
        case (acc_bytes)
            3'd1: begin
                st_strb = 4'b0001 << acc_off;
                st_data = {4{new_memory_value[7:0]}};
            end
            3'd2: begin
                st_strb = 4'b0011 << acc_off;
                st_data = {2{new_memory_value[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        lane_word = mem_rdata >> {off_q, 3'b000};
        case (kind_q)
            KIND_LB:  load_val = {{(OPERAND_WIDTH-8){lane_word[7]}}, lane_word[7:0]};
            KIND_LBU: load_val = {{(OPERAND_WIDTH-8){1'b0}}, lane_word[7:0]};
            KIND_LH:  load_val = {{(OPERAND_WIDTH-16){lane_word[15]}}, lane_word[15:0]};
            KIND_LHU: load_val = {{(OPERAND_WIDTH-16){1'b0}}, lane_word[15:0]};
            default:  load_val = lane_word;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wstrb_d = mem_wstrb_q;
        mem_wdata_d = mem_wdata_q;
        kind_d      = kind_q;
        off_d       = off_q;
        rd_d        = rd_q;
        valid_d     = out_free ? 1'b0 : valid_q;
        out_rd_d    = out_rd_q;
        out_wr_d    = out_wr_q;
        out_val_d   = out_val_q;
        mis_d       = mis_q;
        fault_d     = fault_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (valid_input && out_free) begin
                    if (!is_mem || acc_mis) begin
                        valid_d   = 1'b1;
                        out_rd_d  = rd_addr_input;
                        out_wr_d  = !is_mem && write_register;
                        out_val_d = is_mem ? '0 : new_register_value;
                        mis_d     = is_mem;
                        fault_d   = 1'b0;
                    end else begin
                        state_d     = S_WAIT_ACK;
                        mem_req_d   = 1'b1;
                        mem_we_d    = write_memory;
                        mem_addr_d  = {acc_addr[OPERAND_WIDTH-1:2], 2'b00};
                        mem_wstrb_d = write_memory ? st_strb : 4'b0000;
                        mem_wdata_d = write_memory ? st_data : '0;
                        kind_d      = instr_kind_input;
                        off_d       = acc_off;
                        rd_d        = rd_addr_input;
`ifdef MEM_TIMEOUT_EN
                        cnt_d       = '0;
`endif
                    end
                end
            end
            S_WAIT_ACK: begin
                // The output register was drained on entry and nothing else loads it, so it is free here.
                if (mem_ack || timeout) begin
                    state_d     = S_IDLE;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_wstrb_d = 4'b0000;
                    mem_wdata_d = '0;
                    valid_d     = 1'b1;
                    out_rd_d    = rd_q;
                    out_wr_d    = mem_ack && !mem_we_q;
                    out_val_d   = (mem_ack && !mem_we_q) ? load_val : '0;
                    mis_d       = 1'b0;
                    fault_d     = !mem_ack;
                end else begin
`ifdef MEM_TIMEOUT_EN
                    cnt_d = cnt_q + 32'd1;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wstrb_q <= '0;
            mem_wdata_q <= '0;
            kind_q      <= KIND_ALU;
            off_q       <= '0;
            rd_q        <= '0;
            valid_q     <= 1'b0;
            out_rd_q    <= '0;
            out_wr_q    <= 1'b0;
            out_val_q   <= '0;
            mis_q       <= 1'b0;
            fault_q     <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wstrb_q <= mem_wstrb_d;
            mem_wdata_q <= mem_wdata_d;
            kind_q      <= kind_d;
            off_q       <= off_d;
            rd_q        <= rd_d;
            valid_q     <= valid_d;
            out_rd_q    <= out_rd_d;
            out_wr_q    <= out_wr_d;
            out_val_q   <= out_val_d;
            mis_q       <= mis_d;
            fault_q     <= fault_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign stall_output          = (state_q == S_WAIT_ACK) || (valid_q && stall_input);
    assign mem_req               = mem_req_q;
    assign mem_we                = mem_we_q;
    assign mem_addr              = mem_addr_q;
    assign mem_wstrb             = mem_wstrb_q;
    assign mem_wdata             = mem_wdata_q;
    assign valid_output          = valid_q;
    assign rd_addr_output        = out_rd_q;
    assign write_register_output = out_wr_q;
    assign register_value_output = out_val_q;
    assign misaligned            = mis_q;
    assign access_fault          = fault_q;
endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: directed plan cases plus randomized traffic against a byte-level memory model.
module tb_memory_access;
    import memory_access_pkg::*;

    localparam int TB_TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_input = 1'b0, stall_input = 1'b0;
    instr_kind_t instr_kind_input = KIND_ALU;
    logic [31:0] new_register_value = '0, read_memory_address = '0, write_memory_address = '0, new_memory_value = '0;
    logic [4:0]  rd_addr_input = '0;
    logic        write_register = 1'b0, read_memory = 1'b0, write_memory = 1'b0;
    logic        stall_output, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        valid_output, write_register_output, misaligned, access_fault;
    logic [4:0]  rd_addr_output;
    logic [31:0] register_value_output;

    always #5 clk = ~clk;

    memory_access #(.OPERAND_WIDTH(32), .TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .valid_input(valid_input), .stall_input(stall_input),
        .instr_kind_input(instr_kind_input), .new_register_value(new_register_value),
        .read_memory_address(read_memory_address), .write_memory_address(write_memory_address),
        .new_memory_value(new_memory_value), .rd_addr_input(rd_addr_input),
        .write_register(write_register), .read_memory(read_memory), .write_memory(write_memory),
        .stall_output(stall_output), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .valid_output(valid_output), .rd_addr_output(rd_addr_output),
        .write_register_output(write_register_output), .register_value_output(register_value_output),
        .misaligned(misaligned), .access_fault(access_fault)
    );

    int n_cmp = 0, n_err = 0;
    byte unsigned bus_mem[64];
    byte unsigned ref_mem[64];

    logic        o_req, o_we, o_valid, o_wr, o_mis, o_fault, o_stall_ok, o_expired;
    logic [31:0] o_addr, o_wdata, o_val;
    logic [3:0]  o_wstrb;
    logic [4:0]  o_rd;
    int          o_req_cycles;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int nbytes_of(input instr_kind_t k);
        if (k == KIND_LB || k == KIND_LBU || k == KIND_SB) return 1;
        if (k == KIND_LH || k == KIND_LHU || k == KIND_SH) return 2;
        return 4;
    endfunction

    // Present one bundle, answer the access after `waits` request cycles, capture the result, then drain it.
    task automatic do_mem(input instr_kind_t k, input logic rm, input logic wm, input logic [31:0] addr,
                          input logic [31:0] nrv, input logic [31:0] nmv, input logic [4:0] rd,
                          input logic wr, input int waits, input logic [31:0] rdata);
        int c;
        instr_kind_input     = k;
        read_memory          = rm;
        write_memory         = wm;
        read_memory_address  = (rm && !wm) ? addr : $urandom;
        write_memory_address = wm ? addr : $urandom;
        new_register_value   = nrv;
        new_memory_value     = nmv;
        rd_addr_input        = rd;
        write_register       = wr;
        stall_input          = 1'b0;
        valid_input          = 1'b1;
        tick();
        valid_input = 1'b0;
        o_req = mem_req; o_we = mem_we; o_addr = mem_addr; o_wstrb = mem_wstrb; o_wdata = mem_wdata;
        o_stall_ok = 1'b1; o_req_cycles = 0; o_expired = 1'b0;
        c = 0;
        while (!valid_output) begin
            if (c >= 64) begin
                o_expired = 1'b1;
                break;
            end
            if (mem_req) o_req_cycles++;
            if (!stall_output) o_stall_ok = 1'b0;
            mem_ack   = (c == waits);
            mem_rdata = (c == waits) ? rdata : $urandom;
            tick();
            c++;
        end
        mem_ack = 1'b0;
        o_valid = valid_output; o_wr = write_register_output; o_val = register_value_output;
        o_rd = rd_addr_output; o_mis = misaligned; o_fault = access_fault;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        valid_input = 1'b1; instr_kind_input = KIND_LW; read_memory = 1'b1; read_memory_address = 32'h40;
        repeat (2) tick();
        n_cmp++;
        if ({stall_output, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata, valid_output, rd_addr_output,
             write_register_output, register_value_output, misaligned, access_fault} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got req=%b valid=%b stall=%b addr=%h val=%h want all zero",
                     mem_req, valid_output, stall_output, mem_addr, register_value_output);
        end
        valid_input = 1'b0; read_memory = 1'b0;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_alu();
        do_mem(KIND_ALU, 1'b0, 1'b0, 32'h0, 32'h0000_0007, 32'h0, 5'd5, 1'b1, 0, 32'h0);
        n_cmp++;
        if ({o_valid, o_rd, o_wr, o_val, o_req, o_mis} !== {1'b1, 5'd5, 1'b1, 32'h7, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL alu_result: got v=%b rd=%0d wr=%b val=%h req=%b want v=1 rd=5 wr=1 val=7 req=0",
                     o_valid, o_rd, o_wr, o_val, o_req);
        end
        n_cmp++;
        if (valid_output !== 1'b0) begin
            n_err++;
            $display("FAIL alu_consumed: got valid=%b want 0", valid_output);
        end
    endtask

    task automatic test_store_sb();
        do_mem(KIND_SB, 1'b0, 1'b1, 32'h1003, 32'h0, 32'h1234_56AB, 5'd9, 1'b0, 2, 32'h0);
        n_cmp++;
        if ({o_req, o_we, o_addr, o_wstrb, o_wdata} !== {1'b1, 1'b1, 32'h1000, 4'b1000, 32'hABAB_ABAB}) begin
            n_err++;
            $display("FAIL sb_request: got req=%b we=%b addr=%h strb=%b data=%h want 1 1 00001000 1000 abababab",
                     o_req, o_we, o_addr, o_wstrb, o_wdata);
        end
        n_cmp++;
        if ({o_stall_ok, o_req_cycles} !== {1'b1, 32'd3}) begin
            n_err++;
            $display("FAIL sb_wait: got stall_ok=%b req_cycles=%0d want 1 3", o_stall_ok, o_req_cycles);
        end
        n_cmp++;
        if ({o_valid, o_wr, o_mis, o_fault, o_expired} !== 5'b10000) begin
            n_err++;
            $display("FAIL sb_result: got v=%b wr=%b mis=%b fault=%b exp=%b want 1 0 0 0 0",
                     o_valid, o_wr, o_mis, o_fault, o_expired);
        end
        n_cmp++;
        if ({mem_req, stall_output} !== 2'b00) begin
            n_err++;
            $display("FAIL sb_release: got req=%b stall=%b want 0 0", mem_req, stall_output);
        end
    endtask

    task automatic test_loads();
        do_mem(KIND_LB, 1'b1, 1'b0, 32'h2001, 32'h0, 32'h0, 5'd1, 1'b1, 1, 32'h0000_8000);
        n_cmp++;
        if ({o_addr, o_we, o_val, o_wr} !== {32'h2000, 1'b0, 32'hFFFF_FF80, 1'b1}) begin
            n_err++;
            $display("FAIL lb_result: got addr=%h we=%b val=%h wr=%b want 00002000 0 ffffff80 1", o_addr, o_we, o_val, o_wr);
        end
        do_mem(KIND_LBU, 1'b1, 1'b0, 32'h2001, 32'h0, 32'h0, 5'd2, 1'b1, 0, 32'h0000_8000);
        n_cmp++;
        if ({o_val, o_wr} !== {32'h0000_0080, 1'b1}) begin
            n_err++;
            $display("FAIL lbu_result: got val=%h wr=%b want 00000080 1", o_val, o_wr);
        end
        do_mem(KIND_LH, 1'b1, 1'b0, 32'h3002, 32'h0, 32'h0, 5'd3, 1'b1, 0, 32'hBEEF_0000);
        n_cmp++;
        if ({o_req, o_val, o_mis} !== {1'b1, 32'hFFFF_BEEF, 1'b0}) begin
            n_err++;
            $display("FAIL lh_upper_half: got req=%b val=%h mis=%b want 1 ffffbeef 0", o_req, o_val, o_mis);
        end
        do_mem(KIND_LHU, 1'b1, 1'b0, 32'h3002, 32'h0, 32'h0, 5'd3, 1'b1, 0, 32'hBEEF_0000);
        n_cmp++;
        if (o_val !== 32'h0000_BEEF) begin
            n_err++;
            $display("FAIL lhu_upper_half: got val=%h want 0000beef", o_val);
        end
    endtask

    task automatic test_misaligned();
        do_mem(KIND_LW, 1'b1, 1'b0, 32'h3002, 32'h0, 32'h0, 5'd4, 1'b1, 0, 32'h0);
        n_cmp++;
        if ({o_req, o_valid, o_mis, o_wr, o_fault} !== 5'b01100) begin
            n_err++;
            $display("FAIL lw_misaligned: got req=%b v=%b mis=%b wr=%b fault=%b want 0 1 1 0 0",
                     o_req, o_valid, o_mis, o_wr, o_fault);
        end
        do_mem(KIND_SH, 1'b0, 1'b1, 32'h3001, 32'h0, 32'h5555, 5'd4, 1'b0, 0, 32'h0);
        n_cmp++;
        if ({o_req, o_valid, o_mis, o_wr} !== 4'b0110) begin
            n_err++;
            $display("FAIL sh_misaligned: got req=%b v=%b mis=%b wr=%b want 0 1 1 0", o_req, o_valid, o_mis, o_wr);
        end
    endtask

    task automatic test_ack_idle();
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        repeat (2) tick();
        mem_ack = 1'b0;
        n_cmp++;
        if ({valid_output, mem_req, stall_output} !== 3'b000) begin
            n_err++;
            $display("FAIL ack_idle: got valid=%b req=%b stall=%b want 0 0 0", valid_output, mem_req, stall_output);
        end
    endtask

    task automatic test_back_to_back_hold();
        int add_seen = 0, lh_seen = 0;
        instr_kind_input = KIND_ALU; read_memory = 1'b0; write_memory = 1'b0;
        new_register_value = 32'h55; rd_addr_input = 5'd3; write_register = 1'b1;
        stall_input = 1'b0; valid_input = 1'b1;
        tick();
        instr_kind_input = KIND_LH; read_memory = 1'b1; read_memory_address = 32'h4000;
        rd_addr_input = 5'd7; stall_input = 1'b1;
        #1;
        n_cmp++;
        if (stall_output !== 1'b1) begin
            n_err++;
            $display("FAIL hold_stall_out: got %b want 1", stall_output);
        end
        for (int i = 0; i < 3; i++) begin
            if (valid_output && register_value_output == 32'h55 && rd_addr_output == 5'd3) add_seen++;
            tick();
        end
        n_cmp++;
        if ({add_seen, valid_output, register_value_output, mem_req} !== {32'd3, 1'b1, 32'h55, 1'b0}) begin
            n_err++;
            $display("FAIL hold_add: got seen=%0d v=%b val=%h req=%b want 3 1 00000055 0",
                     add_seen, valid_output, register_value_output, mem_req);
        end
        stall_input = 1'b0;
        tick();
        valid_input = 1'b0;
        n_cmp++;
        if ({mem_req, valid_output, mem_addr} !== {1'b1, 1'b0, 32'h4000}) begin
            n_err++;
            $display("FAIL hold_release: got req=%b v=%b addr=%h want 1 0 00004000", mem_req, valid_output, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 32'h1234_8001;
        tick();
        mem_ack = 1'b0; stall_input = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (valid_output && register_value_output == 32'hFFFF_8001 && rd_addr_output == 5'd7
                && write_register_output) lh_seen++;
            tick();
        end
        stall_input = 1'b0;
        if (valid_output && register_value_output == 32'hFFFF_8001) lh_seen++;
        tick();
        n_cmp++;
        if ({lh_seen, valid_output} !== {32'd4, 1'b0}) begin
            n_err++;
            $display("FAIL hold_lh: got seen=%0d v_after=%b want 4 0", lh_seen, valid_output);
        end
    endtask

    task automatic test_reset_mid_access();
        do_mem(KIND_ALU, 1'b0, 1'b0, 32'h0, 32'h1, 32'h0, 5'd1, 1'b1, 0, 32'h0);
        instr_kind_input = KIND_LW; read_memory = 1'b1; write_memory = 1'b0;
        read_memory_address = 32'h3000; valid_input = 1'b1;
        tick();
        valid_input = 1'b0;
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({mem_req, stall_output} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_mid_access: got req=%b stall=%b want 0 0", mem_req, stall_output);
        end
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_random();
        int          cls, o, wi, n, waits, base;
        instr_kind_t k;
        logic [31:0] a, nrv, nmv, rdata, exp_wdata;
        logic [3:0]  exp_strb;
        logic        rm, wm, wr, mis;
        logic [4:0]  rd;
        longint      v;
        for (int i = 0; i < 64; i++) begin
            bus_mem[i] = 8'($urandom);
            ref_mem[i] = bus_mem[i];
        end
        for (int t = 0; t < 120; t++) begin
            cls = $urandom_range(0, 2);
            o = $urandom_range(0, 3); wi = $urandom_range(0, 14);
            a = 32'h100 + 32'(wi * 4 + o);
            nrv = $urandom; nmv = $urandom; rd = 5'($urandom); wr = 1'($urandom);
            waits = $urandom_range(0, 2);
            rm = 1'b0; wm = 1'b0;
            case (cls)
                0: k = KIND_ALU;
                1: begin
                    k = instr_kind_t'(32'($urandom_range(1, 5)));
                    rm = 1'b1;
                end
                default: begin
                    k = instr_kind_t'(32'($urandom_range(6, 8)));
                    wm = 1'b1; rm = 1'($urandom);
                end
            endcase
            n = nbytes_of(k);
            mis = (cls != 0) && ((n == 2 && (o % 2) != 0) || (n == 4 && o != 0));
            base = wi * 4;
            rdata = {bus_mem[base+3], bus_mem[base+2], bus_mem[base+1], bus_mem[base]};
            do_mem(k, rm, wm, a, nrv, nmv, rd, wr, waits, rdata);
            n_cmp++;
            if (o_expired || !o_valid) begin
                n_err++;
                $display("FAIL rnd_complete[%0d]: got valid=%b expired=%b want 1 0", t, o_valid, o_expired);
            end else if (cls == 0) begin
                n_cmp++;
                if ({o_val, o_wr, o_rd, o_mis, o_req} !== {nrv, wr, rd, 1'b0, 1'b0}) begin
                    n_err++;
                    $display("FAIL rnd_alu[%0d]: got val=%h wr=%b rd=%0d mis=%b req=%b want %h %b %0d 0 0",
                             t, o_val, o_wr, o_rd, o_mis, o_req, nrv, wr, rd);
                end
            end else if (mis) begin
                n_cmp++;
                if ({o_req, o_mis, o_wr} !== 3'b010) begin
                    n_err++;
                    $display("FAIL rnd_misaligned[%0d]: got req=%b mis=%b wr=%b want 0 1 0", t, o_req, o_mis, o_wr);
                end
            end else if (cls == 2) begin
                exp_strb = 4'(((1 << n) - 1) << o);
                for (int b = 0; b < 4; b++) exp_wdata[8*b +: 8] = nmv[8*(b % n) +: 8];
                n_cmp++;
                if ({o_req, o_we, o_addr, o_wstrb, o_wdata, o_wr, o_mis} !==
                    {1'b1, 1'b1, 32'h100 + 32'(base), exp_strb, exp_wdata, 1'b0, 1'b0}) begin
                    n_err++;
                    $display("FAIL rnd_store[%0d]: got we=%b addr=%h strb=%b data=%h want addr=%h strb=%b data=%h",
                             t, o_we, o_addr, o_wstrb, o_wdata, 32'h100 + 32'(base), exp_strb, exp_wdata);
                end
                for (int b = 0; b < 4; b++) if (o_wstrb[b]) bus_mem[base + b] = o_wdata[8*b +: 8];
                for (int j = 0; j < n; j++) ref_mem[base + o + j] = nmv[8*j +: 8];
            end else begin
                v = 0;
                for (int j = 0; j < n; j++) v += longint'(ref_mem[base + o + j]) << (8 * j);
                if ((k == KIND_LB || k == KIND_LH) && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
                n_cmp++;
                if ({o_we, o_addr, o_val, o_wr, o_rd} !== {1'b0, 32'h100 + 32'(base), 32'(v), 1'b1, rd}) begin
                    n_err++;
                    $display("FAIL rnd_load[%0d]: kind=%0d addr=%h got val=%h wr=%b rd=%0d want %h 1 %0d",
                             t, k, a, o_val, o_wr, o_rd, 32'(v), rd);
                end
            end
        end
    endtask

    task automatic test_timeout();
`ifdef MEM_TIMEOUT_EN
        do_mem(KIND_LW, 1'b1, 1'b0, 32'h500, 32'h0, 32'h0, 5'd6, 1'b1, 1000, 32'h0);
        n_cmp++;
        if ({o_expired, o_req_cycles, o_valid, o_fault, o_wr, o_mis} !== {1'b0, 32'd4, 4'b1100}) begin
            n_err++;
            $display("FAIL timeout_fault: got req_cycles=%0d v=%b fault=%b wr=%b mis=%b want 4 1 1 0 0",
                     o_req_cycles, o_valid, o_fault, o_wr, o_mis);
        end
        do_mem(KIND_LW, 1'b1, 1'b0, 32'h504, 32'h0, 32'h0, 5'd6, 1'b1, 1, 32'hCAFE_F00D);
        n_cmp++;
        if ({o_val, o_wr, o_fault} !== {32'hCAFE_F00D, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL timeout_recover: got val=%h wr=%b fault=%b want cafef00d 1 0", o_val, o_wr, o_fault);
        end
        do_mem(KIND_LW, 1'b1, 1'b0, 32'h508, 32'h0, 32'h0, 5'd6, 1'b1, TB_TIMEOUT - 1, 32'h0BAD_F00D);
        n_cmp++;
        if ({o_val, o_wr, o_fault} !== {32'h0BAD_F00D, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL timeout_ack_wins: got val=%h wr=%b fault=%b want 0badf00d 1 0", o_val, o_wr, o_fault);
        end
`else
        do_mem(KIND_LW, 1'b1, 1'b0, 32'h500, 32'h0, 32'h0, 5'd6, 1'b1, 20, 32'h7777_1111);
        n_cmp++;
        if ({o_expired, o_req_cycles, o_val, o_fault} !== {1'b0, 32'd21, 32'h7777_1111, 1'b0}) begin
            n_err++;
            $display("FAIL long_wait: got req_cycles=%0d val=%h fault=%b want 21 77771111 0",
                     o_req_cycles, o_val, o_fault);
        end
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu();
        test_store_sb();
        test_loads();
        test_misaligned();
        test_ack_idle();
        test_back_to_back_hold();
        test_reset_mid_access();
        test_timeout();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
